// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues PC-addressed reads to instruction memory,
// hands the returned word to the decoder and drives PC increment/redirect pulses.
module fetch_ctrl #(
   parameter int DW       = 16,
   parameter int MAX_WAIT = 15,
   parameter int CW       = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   input  logic [DW-1:0] pc_addr,
   output logic          mem_req,
   output logic [DW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] ir_out,
   output logic          ir_valid,
   input  logic          ir_ready,
   input  logic          redirect,
   input  logic          redirect_rel,
   input  logic [DW-1:0] redirect_val,
   output logic          pc_en,
   output logic [1:0]    pc_sel,
   output logic [DW-1:0] pc_in,
   output logic [DW-1:0] pc_branch,
   output logic          timeout_err
);

   typedef enum logic [2:0] {IDLE, WAIT, HOLD, DRAIN, ERR} state_t;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_INC  = 2'b01;
   localparam logic [1:0] SEL_REL  = 2'b10;
   localparam logic [1:0] SEL_ABS  = 2'b11;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          mem_req_d, ir_valid_d, pc_en_d, timeout_d;
   logic [DW-1:0] mem_addr_d, ir_out_d, pc_in_d, pc_branch_d;
   logic [1:0]    pc_sel_d;
   logic          timed_out;

   assign timed_out = (cnt == CW'(MAX_WAIT)) && !mem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         ir_out      <= '0;
         ir_valid    <= 1'b0;
         pc_en       <= 1'b0;
         pc_sel      <= SEL_NONE;
         pc_in       <= '0;
         pc_branch   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         mem_req     <= mem_req_d;
         mem_addr    <= mem_addr_d;
         ir_out      <= ir_out_d;
         ir_valid    <= ir_valid_d;
         pc_en       <= pc_en_d;
         pc_sel      <= pc_sel_d;
         pc_in       <= pc_in_d;
         pc_branch   <= pc_branch_d;
         timeout_err <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      mem_req_d   = mem_req;
      mem_addr_d  = mem_addr;
      ir_out_d    = ir_out;
      ir_valid_d  = ir_valid;
      pc_en_d     = 1'b0;
      pc_sel_d    = SEL_NONE;
      pc_in_d     = pc_in;
      pc_branch_d = pc_branch;
      timeout_d   = timeout_err;

      // A redirect pulses the PC and kills any held instruction in every live state.
      if (redirect && state != ERR) begin
         pc_en_d    = 1'b1;
         ir_valid_d = 1'b0;
         if (redirect_rel) begin
            pc_sel_d    = SEL_REL;
            pc_branch_d = redirect_val;
         end else begin
            pc_sel_d = SEL_ABS;
            pc_in_d  = redirect_val;
         end
      end

      case (state)
         IDLE: begin
            // While a PC pulse is in flight pc_addr is stale; wait one cycle for it to settle.
            if (!redirect && run && !pc_en) begin
               mem_req_d  = 1'b1;
               mem_addr_d = pc_addr;
               cnt_d      = '0;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               if (redirect) begin
                  state_d = IDLE;
               end else begin
                  ir_out_d   = mem_rdata;
                  ir_valid_d = 1'b1;
                  pc_en_d    = 1'b1;
                  pc_sel_d   = SEL_INC;
                  state_d    = HOLD;
               end
            end else if (timed_out) begin
               mem_req_d = 1'b0;
               timeout_d = 1'b1;
               state_d   = ERR;
            end else begin
               cnt_d = cnt + CW'(1);
               if (redirect) state_d = DRAIN;
            end
         end
         HOLD: begin
            if (redirect) begin
               state_d = IDLE;
            end else if (ir_ready) begin
               ir_valid_d = 1'b0;
               if (run) begin
                  // In the first HOLD cycle the increment pulse has not reached the PC yet,
                  // so forward the incremented fetch address instead of the stale pc_addr.
                  mem_req_d  = 1'b1;
                  mem_addr_d = pc_en ? mem_addr + DW'(1) : pc_addr;
                  cnt_d      = '0;
                  state_d    = WAIT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DRAIN: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end else if (timed_out) begin
               mem_req_d = 1'b0;
               timeout_d = 1'b1;
               state_d   = ERR;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small PC model closing the pc_en loop.
module tb_fetch_ctrl;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          run, mem_ack, ir_ready, redirect, redirect_rel;
   logic [DW-1:0] pc_addr, mem_rdata, redirect_val;
   logic          mem_req, ir_valid, pc_en, timeout_err;
   logic [DW-1:0] mem_addr, ir_out, pc_in, pc_branch;
   logic [1:0]    pc_sel;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_ctrl #(.DW(DW), .MAX_WAIT(15), .CW(4)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .pc_addr(pc_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .redirect(redirect), .redirect_rel(redirect_rel), .redirect_val(redirect_val),
      .pc_en(pc_en), .pc_sel(pc_sel), .pc_in(pc_in), .pc_branch(pc_branch),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Program counter as the environment sees it
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_addr <= '0;
      else if (pc_en) begin
         case (pc_sel)
            2'b01: pc_addr <= pc_addr + 16'd1;
            2'b10: pc_addr <= pc_addr + pc_branch;
            2'b11: pc_addr <= pc_in;
            default: pc_addr <= pc_addr;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
      redirect = 1'b0; redirect_rel = 1'b0; mem_rdata = '0; redirect_val = '0;
      repeat (3) tick();
      check("rst mem_req", 32'(mem_req), 0);
      check("rst mem_addr", 32'(mem_addr), 0);
      check("rst ir_valid", 32'(ir_valid), 0);
      check("rst ir_out", 32'(ir_out), 0);
      check("rst pc_en", 32'(pc_en), 0);
      check("rst pc_sel", 32'(pc_sel), 0);
      check("rst timeout", 32'(timeout_err), 0);

      // basic fetch, ack in third request cycle
      rst_n = 1'b1; run = 1'b1; ir_ready = 1'b1;
      tick();
      check("f1 req c1", 32'(mem_req), 1);
      check("f1 addr c1", 32'(mem_addr), 0);
      tick();
      check("f1 req c2", 32'(mem_req), 1);
      tick();
      check("f1 req c3", 32'(mem_req), 1);
      check("f1 addr c3", 32'(mem_addr), 0);
      check("f1 no early valid", 32'(ir_valid), 0);
      mem_ack = 1'b1; mem_rdata = 16'h1234;
      tick();
      mem_ack = 1'b0;
      check("f1 ir_out", 32'(ir_out), 32'h1234);
      check("f1 ir_valid", 32'(ir_valid), 1);
      check("f1 pc_en", 32'(pc_en), 1);
      check("f1 pc_sel", 32'(pc_sel), 1);
      check("f1 req drop", 32'(mem_req), 0);
      tick();
      check("f1 valid one cycle", 32'(ir_valid), 0);
      check("f1 single pc_en", 32'(pc_en), 0);
      check("f1 next req", 32'(mem_req), 1);
      check("f1 next addr", 32'(mem_addr), 1);

      // decoder stall
      ir_ready = 1'b0;
      tick();
      mem_ack = 1'b1; mem_rdata = 16'h5678;
      tick();
      mem_ack = 1'b0;
      check("st ir_valid", 32'(ir_valid), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("st hold valid", 32'(ir_valid), 1);
         check("st hold ir_out", 32'(ir_out), 32'h5678);
         check("st no req", 32'(mem_req), 0);
         check("st no pc_en", 32'(pc_en), 0);
      end
      ir_ready = 1'b1;
      tick();
      check("st valid drop", 32'(ir_valid), 0);
      check("st req same edge", 32'(mem_req), 1);
      check("st addr", 32'(mem_addr), 2);

      // absolute redirect in WAIT, data drained
      redirect = 1'b1; redirect_rel = 1'b0; redirect_val = 16'h0040;
      tick();
      redirect = 1'b0;
      check("ra pc_en", 32'(pc_en), 1);
      check("ra pc_sel", 32'(pc_sel), 3);
      check("ra pc_in", 32'(pc_in), 32'h40);
      check("ra req kept", 32'(mem_req), 1);
      check("ra addr kept", 32'(mem_addr), 2);
      tick();
      check("ra pulse once", 32'(pc_en), 0);
      check("ra drain req", 32'(mem_req), 1);
      tick();
      mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      tick();
      mem_ack = 1'b0;
      check("ra no valid", 32'(ir_valid), 0);
      check("ra req drop", 32'(mem_req), 0);
      check("ra no inc", 32'(pc_en), 0);
      tick();
      check("ra refetch req", 32'(mem_req), 1);
      check("ra refetch addr", 32'(mem_addr), 32'h40);
      check("ra no beef", 32'(ir_valid), 0);

      // relative redirect coincident with ack
      tick();
      mem_ack = 1'b1; mem_rdata = 16'h9999;
      redirect = 1'b1; redirect_rel = 1'b1; redirect_val = 16'hFFFE;
      tick();
      mem_ack = 1'b0; redirect = 1'b0;
      check("rr pc_en", 32'(pc_en), 1);
      check("rr pc_sel", 32'(pc_sel), 2);
      check("rr pc_branch", 32'(pc_branch), 32'hFFFE);
      check("rr pc_in held", 32'(pc_in), 32'h40);
      check("rr no valid", 32'(ir_valid), 0);
      check("rr req drop", 32'(mem_req), 0);
      tick();
      check("rr idle no req", 32'(mem_req), 0);
      check("rr pulse once", 32'(pc_en), 0);
      check("rr pc model", 32'(pc_addr), 32'h3E);
      tick();
      check("rr refetch addr", 32'(mem_addr), 32'h3E);
      check("rr refetch req", 32'(mem_req), 1);

      // timeout after 16 ackless cycles
      repeat (15) tick();
      check("to not yet", 32'(timeout_err), 0);
      check("to req still", 32'(mem_req), 1);
      tick();
      check("to err", 32'(timeout_err), 1);
      check("to req drop", 32'(mem_req), 0);
      redirect = 1'b1; redirect_rel = 1'b0; redirect_val = 16'h0100;
      repeat (2) begin
         tick();
         check("to ign pc_en", 32'(pc_en), 0);
         check("to ign req", 32'(mem_req), 0);
         check("to sticky", 32'(timeout_err), 1);
      end
      redirect = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("to rst clears", 32'(timeout_err), 0);
      check("to rst pc_sel", 32'(pc_sel), 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post rst req", 32'(mem_req), 1);
      check("post rst addr", 32'(mem_addr), 0);

      // async reset mid-WAIT
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("ar req", 32'(mem_req), 0);
      check("ar valid", 32'(ir_valid), 0);
      check("ar pc_en", 32'(pc_en), 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("ar restart req", 32'(mem_req), 1);
      check("ar restart addr", 32'(mem_addr), 0);
      mem_ack = 1'b1; mem_rdata = 16'hABCD;
      tick();
      mem_ack = 1'b0;
      check("ar fetch ir_out", 32'(ir_out), 32'hABCD);
      check("ar fetch pc_sel", 32'(pc_sel), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction fetch controller that sits between the program counter, the instruction memory and the decoder.
- Reads the current PC address and issues a req/ack read to instruction memory.
- Latches the returned word into an instruction register with a valid/ready handshake to the decoder.
- Drives the PC control interface: a one-cycle enable pulse with select, absolute target and branch offset for increment and redirects.

Parameters:
- DW, 16, instruction and address width
- MAX_WAIT, 15, maximum WAIT/DRAIN cycles without mem_ack before timeout
- CW, 4, width of wait counter; must hold MAX_WAIT

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  fetch enable; new requests are issued only while high
- pc_addr  in  DW  current PC value
- mem_req  out  1  memory read request, held until ack
- mem_addr  out  DW  read address, stable while mem_req=1
- mem_ack  in  1  one-cycle read completion; mem_rdata valid in the same cycle
- mem_rdata  in  DW  read data
- ir_out  out  DW  fetched instruction
- ir_valid  out  1  ir_out valid
- ir_ready  in  1  decoder accepts ir_out
- redirect  in  1  one-cycle jump/branch request from execute
- redirect_rel  in  1  1: relative (offset), 0: absolute (target)
- redirect_val  in  DW  target or signed offset
- pc_en  out  1  one-cycle PC update pulse
- pc_sel  out  2  11 absolute, 10 relative, 01 increment, 00 when pc_en=0
- pc_in  out  DW  absolute target, valid with pc_sel=11
- pc_branch  out  DW  offset, valid with pc_sel=10
- timeout_err  out  1  sticky memory timeout flag

Behaviour:
- All outputs are registered.
- Reset: state=IDLE; every output and the wait counter are 0; ir_out=0.
- States: IDLE, WAIT, HOLD, DRAIN, ERR.
- IDLE, run=1: next edge mem_req=1, mem_addr=pc_addr, cnt=0, go WAIT. run=0: stay.
- WAIT:
  - mem_req and mem_addr are held; cnt increments each cycle without ack.
  - On mem_ack with no redirect: ir_out<=mem_rdata, ir_valid<=1, mem_req<=0; pc_en<=1 with pc_sel=01 for exactly one cycle; go HOLD.
  - Latency: ack cycle N gives ir_valid and pc_en high in N+1. The PC value is updated by N+2.
- HOLD:
  - ir_valid stays high until ir_valid&ir_ready.
  - On that handshake: ir_valid<=0. If run=1, also issue the next request (mem_req=1, mem_addr=pc_addr) and go WAIT; otherwise go IDLE.
  - No bubble is inserted when ir_ready is already high.
- redirect, any state except ERR, on the next edge:
  - Assert pc_en for one cycle.
  - redirect_rel=0: pc_sel=11, pc_in=redirect_val. redirect_rel=1: pc_sel=10, pc_branch=redirect_val. The offset applies to the PC value at the edge the pulse is seen.
  - Clear ir_valid and discard the held instruction.
  - From IDLE or HOLD: go IDLE.
  - From WAIT: the request cannot be cancelled. Go DRAIN; keep mem_req/mem_addr; do not reset cnt.
- Redirect coincident with mem_ack in WAIT: the redirect wins. Data is discarded, no increment pulse, mem_req<=0, go IDLE.
- DRAIN:
  - On mem_ack: discard data, mem_req<=0, go IDLE.
  - A further redirect in DRAIN issues another pc_en pulse; relative offsets accumulate. State stays DRAIN, or goes IDLE if it coincides with ack.
- Timeout: in WAIT or DRAIN, if cnt==MAX_WAIT and mem_ack=0, then mem_req<=0, timeout_err<=1, go ERR.
- ERR: absorbing. Ignores run, redirect and mem_ack; exits only by reset.
- pc_en is never high in two consecutive cycles, except back-to-back redirects.
- pc_in and pc_branch hold their last value when pc_en=0.
- Asynchronous reset mid-transaction returns to the reset state immediately. The memory side must tolerate mem_req dropping.

Test Plan:
- Reset then run=1, pc_addr=0x0000, ack after 2 cycles with rdata=0x1234, ir_ready=1 -> mem_addr=0x0000 held 3 cycles, ir_out=0x1234, ir_valid one cycle, single pc_en with pc_sel=01, next mem_addr=0x0001.
- ir_ready=0 for 5 cycles after a fetch -> ir_valid and ir_out held stable, no new mem_req, no extra pc_en; on ready, next request issues in the same edge.
- Redirect rel=0 val=0x0040 while in WAIT, ack 3 cycles later with 0xBEEF -> one pc_en with pc_sel=11, pc_in=0x0040; 0xBEEF never appears with ir_valid=1; next mem_addr=0x0040.
- Redirect rel=1 val=0xFFFE coincident with mem_ack -> only a pc_sel=10 pulse with pc_branch=0xFFFE, no 01 pulse, ir_valid stays 0, back to IDLE.
- No ack for 16 cycles in WAIT (MAX_WAIT=15) -> timeout_err=1, mem_req=0, later redirect/run ignored; rst_n low clears all.
- rst_n asserted low mid-WAIT -> mem_req, ir_valid, pc_en go 0 asynchronously; fetch restarts from IDLE after release.
